// File: rtl/pipelined_adder.sv
// Pipelined adder: {Carry_Out, Sum_Out} = A + B + Carry_In, with the carry chain split into STAGES
// registered slices. Define PIPELINED_ADDER_OVERFLOW_EN to add the signed-overflow output Overflow_Out.
module pipelined_adder #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 4
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic                  Overflow_Out
`endif
);

    localparam int SLICE_W = DATA_WIDTH / STAGES;

    // Handshake: a word moves on any edge where valid & ready are both high; valid never waits on
    // ready. The whole pipe advances as one unit, so ready upstream is just "output free or drained".
    logic adv;
    logic accept;

    assign adv       = Ready_In | ~Valid_Out;
    assign Ready_Out = adv;
    assign accept    = Valid_In & adv;

    // Inputs to the last slice, whether it comes from the ports or from the previous stage.
    logic [SLICE_W-1:0]    fin_a;
    logic [SLICE_W-1:0]    fin_b;
    logic                  fin_c;
    logic                  fin_v;
    logic [SLICE_W:0]      fin_slice;
    logic [DATA_WIDTH-1:0] fin_sum;

    // Intermediate stages: each adds one slice, drops the consumed operand bits and appends its
    // sum slice to the finished lower bits carried alongside.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
        localparam int RW = DATA_WIDTH - k * SLICE_W;

        logic [RW-1:0]            a_in;
        logic [RW-1:0]            b_in;
        logic                     c_in;
        logic                     v_in;
        logic [SLICE_W:0]         slice_sum;
        logic [(k+1)*SLICE_W-1:0] s_d;
        logic [(k+1)*SLICE_W-1:0] s_q;
        logic [RW-SLICE_W-1:0]    ra_q;
        logic [RW-SLICE_W-1:0]    rb_q;
        logic                     c_q;
        logic                     v_q;

        if (k == 0) begin : g_first
            assign a_in = Data_A_In;
            assign b_in = Data_B_In;
            assign c_in = Carry_In;
            assign v_in = accept;
            assign s_d  = slice_sum[SLICE_W-1:0];
        end else begin : g_next
            assign a_in = g_mid[k-1].ra_q;
            assign b_in = g_mid[k-1].rb_q;
            assign c_in = g_mid[k-1].c_q;
            assign v_in = g_mid[k-1].v_q;
            assign s_d  = {slice_sum[SLICE_W-1:0], g_mid[k-1].s_q};
        end

        assign slice_sum = {1'b0, a_in[SLICE_W-1:0]} + {1'b0, b_in[SLICE_W-1:0]}
                         + {{SLICE_W{1'b0}}, c_in};

        always_ff @(posedge Clock_In or negedge Reset_n_In) begin
            if (!Reset_n_In) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                s_q  <= '0;
                ra_q <= '0;
                rb_q <= '0;
            end else if (adv) begin
                v_q  <= v_in;
                c_q  <= slice_sum[SLICE_W];
                s_q  <= s_d;
                ra_q <= a_in[RW-1:SLICE_W];
                rb_q <= b_in[RW-1:SLICE_W];
            end
        end
    end

    if (STAGES == 1) begin : g_single
        assign fin_a   = Data_A_In;
        assign fin_b   = Data_B_In;
        assign fin_c   = Carry_In;
        assign fin_v   = accept;
        assign fin_sum = fin_slice[SLICE_W-1:0];
    end else begin : g_multi
        assign fin_a   = g_mid[STAGES-2].ra_q;
        assign fin_b   = g_mid[STAGES-2].rb_q;
        assign fin_c   = g_mid[STAGES-2].c_q;
        assign fin_v   = g_mid[STAGES-2].v_q;
        assign fin_sum = {fin_slice[SLICE_W-1:0], g_mid[STAGES-2].s_q};
    end

    assign fin_slice = {1'b0, fin_a} + {1'b0, fin_b} + {{SLICE_W{1'b0}}, fin_c};

    // Output stage: the top slice completes here, so every result bit leaves from a flop together.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            Valid_Out <= 1'b0;
            Carry_Out <= 1'b0;
            Sum_Out   <= '0;
        end else if (adv) begin
            Valid_Out <= fin_v;
            Carry_Out <= fin_slice[SLICE_W];
            Sum_Out   <= fin_sum;
        end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    // Signed overflow: operands agree in sign but the result sign differs.
    logic ovf_d;

    assign ovf_d = (fin_a[SLICE_W-1] == fin_b[SLICE_W-1])
                 & (fin_slice[SLICE_W-1] != fin_a[SLICE_W-1]);

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            Overflow_Out <= 1'b0;
        end else if (adv) begin
            Overflow_Out <= ovf_d;
        end
    end
`endif

endmodule
